// File: rtl/sdhci_obi_pkg.sv
// Shared types and constants for the SDHCI OBI register front end.
package sdhci_obi_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;
  localparam int unsigned ObiIdWidth   = 4;
  localparam int unsigned RegIdxWidth  = 6;

  // Size of the decoded SDHCI register window
  localparam int unsigned SdhciRegSpaceBytes = 'h100;

  // SDHCI register byte offsets
  localparam logic [7:0] SdmaSysAddr         = 8'h00;
  localparam logic [7:0] BlockSizeCount      = 8'h04;
  localparam logic [7:0] Argument            = 8'h08;
  localparam logic [7:0] TransferModeCommand = 8'h0C;
  localparam logic [7:0] Response0           = 8'h10;
  localparam logic [7:0] Response1           = 8'h14;
  localparam logic [7:0] Response2           = 8'h18;
  localparam logic [7:0] Response3           = 8'h1C;
  localparam logic [7:0] BufferData          = 8'h20;
  localparam logic [7:0] PresentState        = 8'h24;
  localparam logic [7:0] HostPowerGapWakeup  = 8'h28;
  localparam logic [7:0] ClockControl        = 8'h2C;
  localparam logic [7:0] IntStatus           = 8'h30;
  localparam logic [7:0] IntStatusEnable     = 8'h34;
  localparam logic [7:0] IntSignalEnable     = 8'h38;
  localparam logic [7:0] AutoCmdErr          = 8'h3C;
  localparam logic [7:0] Capabilities        = 8'h40;
  localparam logic [7:0] HostControllerVer   = 8'hFC;

  // OBI A-channel payload
  typedef struct packed {
    logic [ObiAddrWidth-1:0] addr;
    logic                    we;
    logic [ObiBeWidth-1:0]   be;
    logic [ObiDataWidth-1:0] wdata;
    logic [ObiIdWidth-1:0]   aid;
  } sdhci_obi_a_chan_t;

  // OBI request bundle
  typedef struct packed {
    logic              req;
    sdhci_obi_a_chan_t a;
  } sdhci_obi_req_t;

  // OBI R-channel payload
  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
    logic [ObiIdWidth-1:0]   rid;
  } sdhci_obi_r_chan_t;

  // OBI response bundle
  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    sdhci_obi_r_chan_t r;
  } sdhci_obi_rsp_t;

  // Response channel state
  typedef enum logic {
    RSP_IDLE  = 1'b0,
    RSP_VALID = 1'b1
  } rsp_state_e;

endpackage : sdhci_obi_pkg

// File: rtl/sdhci_obi_reg_adapter.sv
// OBI subordinate that turns bus requests into single-cycle register-file
// accesses, with a one-cycle registered response and a bounded stall timer.
module sdhci_obi_reg_adapter
  import sdhci_obi_pkg::*;
#(
  parameter type         obi_req_t    = sdhci_obi_req_t,
  parameter type         obi_rsp_t    = sdhci_obi_rsp_t,
  parameter int unsigned StallTimeout = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  obi_req_t                obi_req_i,
  output obi_rsp_t                obi_rsp_o,
  output logic                    reg_valid_o,
  input  logic                    reg_ready_i,
  output logic                    reg_we_o,
  output logic [RegIdxWidth-1:0]  reg_addr_o,
  output logic [ObiBeWidth-1:0]   reg_be_o,
  output logic [ObiDataWidth-1:0] reg_wdata_o,
  input  logic [ObiDataWidth-1:0] reg_rdata_i,
  output logic                    timeout_o
);

  // A zero timeout still needs a legal one-bit counter
  localparam int unsigned CntWidth = (StallTimeout > 0) ? $clog2(StallTimeout + 1) : 1;
  localparam int unsigned IdWidth  = $bits(obi_req_i.a.aid);
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(StallTimeout);

  rsp_state_e              r_state;
  logic [CntWidth-1:0]     r_cnt;
  logic [ObiDataWidth-1:0] r_rdata;
  logic                    r_err;
  logic [IdWidth-1:0]      r_rid;
  logic                    r_timeout;

  logic w_req;
  logic w_mapped;
  logic w_timeout;
  logic w_valid;
  logic w_hs;
  logic w_gnt;
  logic w_unused;

  // Address byte offset within a word carries no meaning for word registers
  assign w_unused = ^obi_req_i.a.addr[1:0];

  // Request decode and grant generation, all combinational from the bus
  assign w_req     = obi_req_i.req;
  assign w_mapped  = (obi_req_i.a.addr[ObiAddrWidth-1:8] == '0);
  assign w_timeout = (StallTimeout != 0) && w_req && w_mapped && (r_cnt == CntLimit);
  assign w_valid   = w_req && w_mapped && !w_timeout;
  assign w_hs      = w_valid && reg_ready_i;
  assign w_gnt     = w_hs || w_timeout || (w_req && !w_mapped);

  // Register-file side of the access is a straight pass-through
  assign reg_valid_o = w_valid;
  assign reg_we_o    = obi_req_i.a.we;
  assign reg_addr_o  = obi_req_i.a.addr[7:2];
  assign reg_be_o    = obi_req_i.a.be;
  assign reg_wdata_o = obi_req_i.a.wdata;
  assign timeout_o   = r_timeout;

  // Assemble the OBI response from the grant and the response registers
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = w_gnt;
    obi_rsp_o.rvalid  = (r_state == RSP_VALID);
    obi_rsp_o.r.rdata = r_rdata;
    obi_rsp_o.r.err   = r_err;
    obi_rsp_o.r.rid   = r_rid;
  end

  // Stall counter: counts back-pressured cycles, saturates at the limit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!w_req || w_gnt) begin
      r_cnt <= '0;
    end else if (w_mapped && !reg_ready_i && (r_cnt < CntLimit)) begin
      r_cnt <= r_cnt + CntWidth'(1);
    end
  end

  // Response state and payload, captured on every grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= RSP_IDLE;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_rid     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_gnt) begin
        r_state <= RSP_VALID;
        r_rdata <= (w_hs && !obi_req_i.a.we) ? reg_rdata_i : '0;
        r_err   <= !w_hs;
        r_rid   <= obi_req_i.a.aid;
      end else begin
        r_state <= RSP_IDLE;
      end
    end
  end

endmodule : sdhci_obi_reg_adapter

// File: tb/tb_sdhci_obi_reg_adapter.sv
// Directed self-checking bench for sdhci_obi_reg_adapter.
module tb_sdhci_obi_reg_adapter;
  import sdhci_obi_pkg::*;

  logic           clk;
  logic           rst;
  sdhci_obi_req_t req;
  sdhci_obi_rsp_t rsp;
  logic           reg_valid;
  logic           reg_ready;
  logic           reg_we;
  logic [5:0]     reg_addr;
  logic [3:0]     reg_be;
  logic [31:0]    reg_wdata;
  logic [31:0]    reg_rdata;
  logic           tmo;

  sdhci_obi_req_t req8;
  sdhci_obi_rsp_t rsp8;
  logic           reg_valid8;
  logic           reg_ready8;
  logic           reg_we8;
  logic [5:0]     reg_addr8;
  logic [3:0]     reg_be8;
  logic [31:0]    reg_wdata8;
  logic [31:0]    reg_rdata8;
  logic           tmo8;

  int checks;
  int failures;

  sdhci_obi_reg_adapter #(.StallTimeout(64)) dut (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_rsp_o(rsp),
    .reg_valid_o(reg_valid), .reg_ready_i(reg_ready), .reg_we_o(reg_we),
    .reg_addr_o(reg_addr), .reg_be_o(reg_be), .reg_wdata_o(reg_wdata),
    .reg_rdata_i(reg_rdata), .timeout_o(tmo)
  );

  sdhci_obi_reg_adapter #(.StallTimeout(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req8), .obi_rsp_o(rsp8),
    .reg_valid_o(reg_valid8), .reg_ready_i(reg_ready8), .reg_we_o(reg_we8),
    .reg_addr_o(reg_addr8), .reg_be_o(reg_be8), .reg_wdata_o(reg_wdata8),
    .reg_rdata_i(reg_rdata8), .timeout_o(tmo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
    req.req     = v;
    req.a.addr  = addr;
    req.a.we    = we;
    req.a.be    = be;
    req.a.wdata = wdata;
    req.a.aid   = aid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gnt_cnt;
    int tmo_cnt;
    int stall;
    logic got;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req        = '0;
    req8       = '0;
    reg_ready  = 1'b1;
    reg_ready8 = 1'b1;
    reg_rdata  = '0;
    reg_rdata8 = '0;

    // Reset values
    tick();
    tick();
    chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
    chk("rst_rdata", rsp.r.rdata, 32'd0);
    chk("rst_err", 32'(rsp.r.err), 32'd0);
    chk("rst_rid", 32'(rsp.r.rid), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    chk("rst_gnt_idle", 32'(rsp.gnt), 32'd0);
    rst = 1'b0;

    // Write ClockControl, single byte lane
    tick();
    drive(1'b1, 32'h0000_002C, 1'b1, 4'b0010, 32'h0000_8000, 4'd1);
    reg_ready = 1'b1;
    #1;
    chk("wr_gnt", 32'(rsp.gnt), 32'd1);
    chk("wr_valid", 32'(reg_valid), 32'd1);
    chk("wr_addr", 32'(reg_addr), 32'h0B);
    chk("wr_be", 32'(reg_be), 32'h2);
    chk("wr_we", 32'(reg_we), 32'd1);
    chk("wr_wdata", reg_wdata, 32'h0000_8000);
    chk("wr_rvalid_early", 32'(rsp.rvalid), 32'd0);
    tick();
    chk("wr_rvalid", 32'(rsp.rvalid), 32'd1);
    chk("wr_err", 32'(rsp.r.err), 32'd0);
    chk("wr_rdata", rsp.r.rdata, 32'd0);
    chk("wr_rid", 32'(rsp.r.rid), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    tick();
    chk("wr_rvalid_drop", 32'(rsp.rvalid), 32'd0);

    // Read IntStatus
    drive(1'b1, 32'h0000_0030, 1'b0, 4'hF, 32'h0, 4'd3);
    reg_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_gnt", 32'(rsp.gnt), 32'd1);
    chk("rd_addr", 32'(reg_addr), 32'h0C);
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    reg_rdata = 32'h0;
    chk("rd_rvalid", 32'(rsp.rvalid), 32'd1);
    chk("rd_rdata", rsp.r.rdata, 32'hDEAD_BEEF);
    chk("rd_rid", 32'(rsp.r.rid), 32'd3);
    chk("rd_err", 32'(rsp.r.err), 32'd0);
    tick();

    // Four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i) | 32'h1, 1'b0, 4'hF, 32'h0, 4'(i + 4));
      reg_rdata = 32'h1000_0000 + 32'(i);
      #1;
      chk("b2b_gnt", 32'(rsp.gnt), 32'd1);
      chk("b2b_addr", 32'(reg_addr), 32'(i));
      if (i > 0) begin
        chk("b2b_rvalid", 32'(rsp.rvalid), 32'd1);
        chk("b2b_rdata", rsp.r.rdata, 32'h1000_0000 + 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    chk("b2b_last_rvalid", 32'(rsp.rvalid), 32'd1);
    chk("b2b_last_rdata", rsp.r.rdata, 32'h1000_0003);
    chk("b2b_last_rid", 32'(rsp.r.rid), 32'd7);
    tick();
    chk("b2b_idle", 32'(rsp.rvalid), 32'd0);

    // BufferData write stalled 10 cycles, below the 64-cycle timeout
    gnt_cnt = 0;
    tmo_cnt = 0;
    drive(1'b1, 32'h0000_0020, 1'b1, 4'hF, 32'hCAFE_0001, 4'd2);
    reg_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp.gnt) gnt_cnt++;
      chk("stall_valid", 32'(reg_valid), 32'd1);
      tick();
      if (tmo) tmo_cnt++;
    end
    chk("stall_no_gnt", 32'(gnt_cnt), 32'd0);
    reg_ready = 1'b1;
    #1;
    chk("stall_gnt", 32'(rsp.gnt), 32'd1);
    chk("stall_hs", 32'(reg_valid & reg_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    if (tmo) tmo_cnt++;
    chk("stall_rvalid", 32'(rsp.rvalid), 32'd1);
    chk("stall_err", 32'(rsp.r.err), 32'd0);
    chk("stall_no_timeout", 32'(tmo_cnt), 32'd0);
    tick();

    // Forced timeout on the 8-cycle instance
    req8.req     = 1'b1;
    req8.a.addr  = 32'h0000_0020;
    req8.a.we    = 1'b1;
    req8.a.be    = 4'hF;
    req8.a.wdata = 32'h1234_5678;
    req8.a.aid   = 4'd9;
    reg_ready8   = 1'b0;
    reg_rdata8   = 32'hFFFF_0000;
    stall = 0;
    got   = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (rsp8.gnt) begin
        got = 1'b1;
        chk("tmo_valid_off", 32'(reg_valid8), 32'd0);
      end else begin
        stall++;
      end
      tick();
    end
    chk("tmo_granted", 32'(got), 32'd1);
    chk("tmo_stall_cycles", 32'(stall), 32'd8);
    req8.req = 1'b0;
    chk("tmo_pulse", 32'(tmo8), 32'd1);
    chk("tmo_rvalid", 32'(rsp8.rvalid), 32'd1);
    chk("tmo_err", 32'(rsp8.r.err), 32'd1);
    chk("tmo_rdata", rsp8.r.rdata, 32'd0);
    chk("tmo_rid", 32'(rsp8.r.rid), 32'd9);
    tick();
    chk("tmo_pulse_end", 32'(tmo8), 32'd0);
    chk("tmo_rvalid_end", 32'(rsp8.rvalid), 32'd0);

    // Unmapped read
    reg_ready = 1'b1;
    drive(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 4'd5);
    reg_rdata = 32'h5A5A_5A5A;
    #1;
    chk("unm_gnt", 32'(rsp.gnt), 32'd1);
    chk("unm_valid", 32'(reg_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    chk("unm_rvalid", 32'(rsp.rvalid), 32'd1);
    chk("unm_err", 32'(rsp.r.err), 32'd1);
    chk("unm_rdata", rsp.r.rdata, 32'd0);
    tick();

    // Reset during a pending response
    drive(1'b1, 32'h0000_0030, 1'b0, 4'hF, 32'h0, 4'd6);
    reg_rdata = 32'hFFFF_FFFF;
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    chk("rstmid_rvalid_pre", 32'(rsp.rvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid_drop", 32'(rsp.rvalid), 32'd0);
    chk("rstmid_rdata", rsp.r.rdata, 32'd0);
    tick();
    chk("rstmid_rvalid_hold", 32'(rsp.rvalid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstmid_rvalid_after", 32'(rsp.rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sdhci_obi_reg_adapter
